// File: rtl/inst_fetch_axi_pkg.sv
// Shared constants and types for the instruction-fetch AXI read master.
package inst_fetch_axi_pkg;
  localparam logic [3:0] AXI_INST_Id    = 4'd0;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {IDLE, AR, R, DRAIN} fetch_state_e;

  // Beat counter width: log2(words per line), never narrower than one bit.
  function automatic int cnt_w(input int lw);
    return (lw <= 2) ? 1 : $clog2(lw);
  endfunction
endpackage

// File: rtl/inst_fetch_axi_line_buf.sv
// Single-line fetch buffer: valid/tag/data with a fill write port and a
// combinational hit/read port.
module fetch_line_buf
  import inst_fetch_axi_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int CW         = cnt_w(LINE_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [CW-1:0] idx,
  input  logic [31:0]   data,
  input  logic          set_valid,
  input  logic          clr_valid,
  input  logic [31:0]   tag,
  input  logic [31:0]   rd_tag,
  input  logic [CW-1:0] rd_idx,
  output logic          rd_hit,
  output logic [31:0]   rd_data
);
  logic                             valid_q;
  logic [31:0]                      tag_q;
  logic [LINE_WORDS-1:0][31:0]      data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (clr_valid) valid_q <= 1'b0;
      else if (set_valid) begin
        valid_q <= 1'b1;
        tag_q   <= tag;
      end
      for (int i = 0; i < LINE_WORDS; i++)
        if (we && idx == CW'(i)) data_q[i] <= data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < LINE_WORDS; i++)
      if (rd_idx == CW'(i)) rd_data = data_q[i];
  end

  assign rd_hit = valid_q & (rd_tag == tag_q);
endmodule

// File: rtl/inst_fetch_axi.sv
// Instruction-fetch AXI read master: one outstanding burst, one-line buffer
// for cached fetches and a one-word register for uncached fetches.
module inst_fetch_axi
  import inst_fetch_axi_pkg::*;
#(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] INST_ID    = AXI_INST_Id
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] pc,
  input  logic        pc_en,
  input  logic        uncached,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        bus_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  localparam int          CW    = cnt_w(LINE_WORDS);
  localparam logic [31:0] LMASK = ~(32'(LINE_WORDS * 4) - 32'd1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   araddr_q, req_pc_q, uc_addr_q, uc_data_q;
  logic [3:0]    arlen_q;
  logic [CW-1:0] cnt_q;
  logic          req_uc_q, err_q, flush_seen_q, uc_valid_q, bus_err_q;

  logic          issue, last_ok, beat, any_err, fill_ok;
  logic          lb_hit, chit, uhit, hit;
  logic [31:0]   lb_data;

  assign beat    = rvalid & (rid == INST_ID);
  assign any_err = err_q | (rresp != AXI_RESP_OKAY);
  assign fill_ok = last_ok & ~any_err;

  fetch_line_buf #(.LINE_WORDS(LINE_WORDS), .CW(CW)) u_lbuf (
    .clk       (clk),
    .reset     (reset),
    .we        (state_q == R && beat && !req_uc_q),
    .idx       (cnt_q),
    .data      (rdata),
    .set_valid (fill_ok & ~req_uc_q),
    .clr_valid (issue & ~uncached),
    .tag       (req_pc_q & LMASK),
    .rd_tag    (pc & LMASK),
    .rd_idx    (CW'((pc >> 2) & 32'(LINE_WORDS - 1))),
    .rd_hit    (lb_hit),
    .rd_data   (lb_data)
  );

  assign chit       = pc_en & ~uncached & lb_hit;
  assign uhit       = pc_en & uncached & uc_valid_q & (pc == uc_addr_q);
  assign hit        = chit | uhit;
  assign inst_valid = hit & ~flush;
  assign inst       = chit ? lb_data : (uhit ? uc_data_q : '0);

  assign arid    = INST_ID;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign bus_err = bus_err_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A flush that lands on the rlast beat itself retires the burst directly
  // instead of waiting in DRAIN for an rlast that will never come.
  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    issue   = 1'b0;
    last_ok = 1'b0;
    case (state_q)
      IDLE: if (pc_en && !hit && !flush) begin
        issue   = 1'b1;
        state_d = AR;
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_d = (flush_seen_q || flush) ? DRAIN : R;
      end
      R: begin
        rready = 1'b1;
        if (beat && rlast) begin
          state_d = IDLE;
          last_ok = ~flush;
        end else if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        rready = 1'b1;
        if (beat && rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      araddr_q     <= '0;
      arlen_q      <= '0;
      req_pc_q     <= '0;
      req_uc_q     <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      flush_seen_q <= 1'b0;
      uc_valid_q   <= 1'b0;
      uc_addr_q    <= '0;
      uc_data_q    <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      bus_err_q <= last_ok & any_err;
      if (issue) begin
        araddr_q     <= uncached ? (pc & 32'h1FFF_FFFC) : (pc & 32'h1FFF_FFFF & LMASK);
        arlen_q      <= uncached ? 4'd0 : 4'(LINE_WORDS - 1);
        req_pc_q     <= pc;
        req_uc_q     <= uncached;
        cnt_q        <= '0;
        err_q        <= 1'b0;
        flush_seen_q <= 1'b0;
        if (uncached) uc_valid_q <= 1'b0;
      end
      if (state_q == AR && flush) flush_seen_q <= 1'b1;
      if (state_q == R && beat) begin
        cnt_q <= cnt_q + CW'(1);
        if (rresp != AXI_RESP_OKAY) err_q <= 1'b1;
      end
      if (fill_ok && req_uc_q) begin
        uc_valid_q <= 1'b1;
        uc_addr_q  <= req_pc_q;
        uc_data_q  <= rdata;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_axi.sv
// Randomized bench for inst_fetch_axi at LINE_WORDS 8, 1 and 16, with the
// bench acting as AXI slave and tracking which fetches must hit.
module tb_inst_fetch_axi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Slave memory contents, keyed by physical word address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int          LW = (g == 0) ? 8 : (g == 1) ? 1 : 16;
    localparam logic [31:0] LM = ~(32'(LW * 4) - 32'd1);

    logic        reset, flush, pc_en, uncached, arready, rlast, rvalid;
    logic [31:0] pc, rdata, inst, araddr;
    logic [3:0]  rid, arid, arlen;
    logic [1:0]  rresp, arburst;
    logic [2:0]  arsize;
    logic        inst_valid, bus_err, arvalid, rready;

    // Reference state: which line / uncached word the fetch unit must hold.
    bit          ln_ok, uc_ok;
    logic [31:0] ln_tag, uc_pc;

    inst_fetch_axi #(.LINE_WORDS(LW), .INST_ID(4'd0)) dut (
      .clk(clk), .reset(reset), .flush(flush), .pc(pc), .pc_en(pc_en),
      .uncached(uncached), .inst(inst), .inst_valid(inst_valid), .bus_err(bus_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready)
    );

    task automatic ck(input string t, input logic [31:0] a, input logic [31:0] e);
      chk($sformatf("L%0d:%s", LW, t), a, e);
    endtask

    function automatic bit model_hit(input logic [31:0] a, input bit u);
      return u ? (uc_ok && a == uc_pc) : (ln_ok && (a & LM) == ln_tag);
    endfunction

    // One miss: issue, AR phase (arw stall cycles, flush at AR cycle fa),
    // R phase (flush on beat fr, error on beat eb), then the retire checks.
    task automatic txn(input logic [31:0] a, input bit u, input int arw,
                       input int fa, input int fr, input int eb);
      int n; logic [31:0] base; bit killed, erred, ok;
      n = u ? 1 : LW;
      base = u ? (a & 32'h1FFF_FFFC) : (a & 32'h1FFF_FFFF & LM);
      pc = a; uncached = u; pc_en = 1'b1; flush = 1'b0;
      @(negedge clk); ck("miss", inst_valid, 0);
      @(posedge clk); #1; pc_en = 1'b0;
      if (u) uc_ok = 0; else ln_ok = 0;
      for (int t = 0; t <= arw; t++) begin
        flush = (t == fa); arready = (t == arw);
        @(negedge clk);
        ck("arvalid", arvalid, 1);
        ck("araddr", araddr, base);
        ck("arlen", 32'(arlen), 32'(n - 1));
        ck("arconst", {arid, arsize, arburst}, {4'd0, 3'b010, 2'b01});
        @(posedge clk); #1;
      end
      flush = 1'b0; arready = 1'b0;
      killed = (fa >= 0 && fa <= arw); erred = 0;
      for (int b = 0; b < n; ) begin
        rvalid = 1'b0; rid = 4'd0; rresp = 2'b00; rlast = 1'b0; flush = 1'b0;
        case ($urandom_range(0, 5))
          0: ;
          1: begin
            rvalid = 1'b1; rid = 4'd1; rdata = $urandom;
            rlast = 1'($urandom_range(0, 1)); rresp = 2'($urandom_range(0, 3));
          end
          default: begin
            rvalid = 1'b1; rdata = mem(base + 32'(4 * b)); rlast = (b == n - 1);
            if (b == eb) begin rresp = 2'b10; erred = 1; end
            if (b == fr && !killed) begin flush = 1'b1; killed = 1; end
            b++;
          end
        endcase
        @(negedge clk); ck("rready", rready, 1);
        @(posedge clk); #1;
      end
      rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rresp = 2'b00; flush = 1'b0;
      ok = !killed && !erred;
      pc_en = ok;
      @(negedge clk);
      ck("bus_err", bus_err, 32'(!killed && erred));
      ck("rready_idle", rready, 0);
      ck("fill_valid", inst_valid, 32'(ok));
      if (ok) ck("fill_inst", inst, mem(a & 32'h1FFF_FFFC));
      if (ok) begin
        if (u) begin uc_ok = 1; uc_pc = a; end
        else begin ln_ok = 1; ln_tag = a & LM; end
      end
      @(posedge clk); #1; pc_en = 1'b0;
      @(negedge clk);
      ck("bus_err_pulse", bus_err, 0);
      ck("ar_idle", arvalid, 0);
      @(posedge clk); #1;
    endtask

    // Present a pc that must hit (or carries flush) and confirm no AR follows.
    task automatic probe(input logic [31:0] a, input bit u, input bit fl);
      bit h;
      h = !fl && model_hit(a, u);
      pc = a; uncached = u; pc_en = 1'b1; flush = fl;
      @(negedge clk);
      ck("hit", inst_valid, 32'(h));
      if (h) ck("hit_inst", inst, mem(a & 32'h1FFF_FFFC));
      @(posedge clk); #1; pc_en = 1'b0; flush = 1'b0;
      @(negedge clk); ck("no_ar", arvalid, 0);
      @(posedge clk); #1;
    endtask

    task automatic step(input logic [31:0] a, input bit u);
      if (model_hit(a, u)) probe(a, u, 0);
      else txn(a, u, $urandom_range(0, 2), -1, -1, -1);
    endtask

    initial begin
      logic [31:0] a; bit u; int sc, arw, n;
      reset = 1'b1; flush = 0; pc = 0; pc_en = 0; uncached = 0; arready = 0;
      rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
      ln_ok = 0; uc_ok = 0; ln_tag = 0; uc_pc = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ck("rst_arvalid", arvalid, 0); ck("rst_rready", rready, 0);
      ck("rst_valid", inst_valid, 0); ck("rst_bus_err", bus_err, 0);
      ck("rst_araddr", araddr, 0); ck("rst_arlen", 32'(arlen), 0);
      ck("rst_inst", inst, 0);
      @(posedge clk); #1; reset = 1'b0;

      txn(32'hBFC0_0004, 0, 0, -1, -1, -1);
      step(32'hBFC0_001C, 0);
      txn(32'hBFC0_0008, 1, 0, -1, -1, -1);
      probe(32'hBFC0_0008, 1, 0);
      step(32'hBFC0_000C, 1);
      txn(32'hBFC0_0040, 0, 4, 2, -1, -1);
      step(32'hBFC0_0040, 0);
      txn(32'hBFC0_0080, 0, 0, -1, (LW > 4) ? 3 : -1, -1);
      txn(32'hBFC0_00C0, 0, 0, -1, -1, (LW > 5) ? 5 : LW - 1);
      txn(32'hBFC0_00C0, 0, 0, -1, -1, -1);

      // Reset while the burst is in R drops straight back to idle.
      pc = 32'hBFC0_0100; uncached = 0; pc_en = 1'b1;
      @(posedge clk); #1; pc_en = 1'b0; arready = 1'b1;
      @(posedge clk); #1; arready = 1'b0; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      ck("rstmid_rready", rready, 0); ck("rstmid_arvalid", arvalid, 0);
      ck("rstmid_araddr", araddr, 0);
      ln_ok = 0; uc_ok = 0;
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) begin
        a = 32'hBFC0_0000 + (32'($urandom_range(0, 63)) << 2);
        u = ($urandom_range(0, 3) == 0);
        n = u ? 1 : LW;
        if ($urandom_range(0, 7) == 0) probe(a, u, 1);
        else if (model_hit(a, u)) probe(a, u, 0);
        else begin
          sc  = $urandom_range(0, 5);
          arw = $urandom_range(0, 3);
          txn(a, u, arw,
              (sc == 3) ? $urandom_range(0, arw) : -1,
              (sc == 4 && n > 1) ? $urandom_range(0, n - 2) : -1,
              (sc == 5) ? $urandom_range(0, n - 1) : -1);
        end
      end
      n_done++;
    end
  end

  initial begin
    for (int c = 0; c < 60000 && n_done < 3; c++) @(posedge clk);
    if (n_done < 3) chk("timeout", 32'(n_done), 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_axi.md
# inst_fetch_axi

Instruction-fetch AXI read master with a single-line fetch buffer. It sits between the PC stage and the AXI crossbar's instruction port. It generalises the fixed 8-word fetch path in three ways: a parametrised line length, full AR/R valid/ready handshakes, and a runtime cached/uncached mode. It also handles flush with outstanding bursts and reports bus errors.

## Interface
Parameters:
- `LINE_WORDS`, default 8: words per line; power of two, 1..16. `OFF = log2(LINE_WORDS*4)`.
- `INST_ID`, default 4'd0: value driven on `arid`; R beats with any other `rid` are ignored.

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: pipeline flush; kills the current request.
- `pc` in 32: fetch address, word aligned.
- `pc_en` in 1: a fetch is requested this cycle.
- `uncached` in 1: 1 = single-beat fetch that bypasses the line buffer.
- `inst` out 32: instruction for `pc`.
- `inst_valid` out 1: `inst` is valid this cycle.
- `bus_err` out 1: one-cycle pulse when a non-OKAY `rresp` is received.
- `arid` out 4, `araddr` out 32, `arlen` out 4, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1: AR channel.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: R channel.

## Operation
- Constant AR fields: `arid=INST_ID`, `arsize=3'b010`, `arburst=2'b01`.
- Cached request: `arlen=LINE_WORDS-1`, `araddr={3'b000, pc[28:OFF], OFF'b0}`.
- Uncached request: `arlen=0`, `araddr={3'b000, pc[28:2], 2'b00}`.
- All AR fields are registered and latched at request issue. They stay stable while `arvalid` is high.
- Line buffer: `line_valid`, `line_tag=pc[31:OFF]`, `LINE_WORDS` data words.
- Cached hit = `pc_en & !uncached & line_valid & (pc[31:OFF]==line_tag)`. On a hit, `inst` = word `pc[OFF-1:2]`.
- Uncached word register: `uc_valid`, `uc_addr`, `uc_data`. Uncached hit = `pc_en & uncached & uc_valid & (pc==uc_addr)`.
- `inst_valid = hit & !flush`. When `inst_valid=0`, `inst` is don't-care.
- FSM states: IDLE, AR, R, DRAIN.
  - IDLE: if `pc_en & !hit & !flush`, latch the request, clear `line_valid` (cached) or `uc_valid` (uncached), and go to AR.
  - AR: `arvalid=1` until `arready`. `arvalid` is never withdrawn, even on flush. On handshake: go to DRAIN if a flush has been seen since issue, else go to R.
  - R: `rready=1`. Each accepted beat with `rid==INST_ID` writes word `cnt` and increments `cnt` (width `OFF-2`, minimum 1).
    - `rresp!=0` on any beat sets a sticky error.
    - On the `rlast` beat: if there is no error, set `line_valid` and `line_tag` (cached), or set `uc_valid`, `uc_addr`, `uc_data` (uncached). Then go to IDLE.
    - If the error is set at `rlast`: pulse `bus_err`, leave the line/word invalid, go to IDLE. The PC stage retries.
    - `flush` in R: go to DRAIN.
  - DRAIN: `rready=1`. Matching beats are discarded. On `rlast`, go to IDLE. No buffer is updated and `bus_err` is suppressed.
- Outside R and DRAIN, `rready=0`.
- At most one burst is outstanding.
- Simultaneous `flush` and `pc_en` in IDLE: no request is issued.
- A buffer hit while the FSM is in R is permitted. It is impossible for the line being filled, because that line's valid bit was cleared at issue.

## Timing
- Reset values: state IDLE; `arvalid=0`, `rready=0`, `inst_valid=0`, `bus_err=0`, `line_valid=0`, `uc_valid=0`, `cnt=0`, `araddr=0`, `arlen=0`, `inst=0`.
- Reset mid-burst returns to IDLE immediately. The interconnect is reset with the core.
- Hit: zero-cycle. `inst_valid` is combinational from registered state plus `pc`.
- Cached miss:
  - Cycle 0: miss seen.
  - Cycle 1: `arvalid` high.
  - Handshake in cycle k.
  - Beats arrive from k+1.
  - `rlast` in cycle m.
  - `inst_valid` in cycle m+1 if `pc` is held.
- Minimum cached miss-to-valid latency is `LINE_WORDS+2` cycles with `arready=1` and back-to-back `rvalid`.
- Uncached minimum latency is 3 cycles.
- `bus_err` is asserted in cycle m+1 only.

## Structure
- Shared package (`defines`): `AXI_INST_Id`, the AXI burst/size/resp encodings, and the FSM state typedef (IDLE/AR/R/DRAIN).
- One natural sub-module, `fetch_line_buf`: the tag/valid/data array, with a write port (`idx`, `data`, `we`, `set_valid`, `clr_valid`, `tag`) and a combinational read/hit port. The FSM and AXI logic stay in the top.

## Test plan
- Cold cached miss:
  - Stimulus: `pc=0xBFC00004`, `LINE_WORDS=8`, `arready=1`, 8 beats 0x100..0x107.
  - Required: `araddr=0x1FC00000`, `arlen=7`; `inst=0x101`, `inst_valid` 10 cycles after the miss; then `pc=0xBFC0001C` hits with 0x107 and no AR.
- Uncached fetch:
  - Stimulus: `pc=0xBFC00008`, `uncached=1`, one beat 0xDEAD.
  - Required: `arlen=0`, `araddr=0x1FC00008`; `inst=0xDEAD` valid; a different `pc` misses.
- AR backpressure plus flush:
  - Stimulus: `arready=0` for 5 cycles, `flush` in cycle 2.
  - Required: `arvalid` stays high through handshake; all 8 beats are drained; `inst_valid` stays 0; `line_valid=0`; the next `pc_en` issues a new AR.
- Flush mid-burst:
  - Stimulus: `flush` during beat 3.
  - Required: DRAIN consumes beats 4..7; no buffer update; no `bus_err`.
- Error:
  - Stimulus: `rresp=2'b10` on beat 5.
  - Required: `bus_err` is a 1-cycle pulse after `rlast`; the line stays invalid; a held `pc_en` reissues the same AR.
- Foreign ID and parameter sweep:
  - Stimulus: interleaved beats with `rid=1`; repeat the run with `LINE_WORDS=1` and `LINE_WORDS=16`.
  - Required: foreign beats are ignored; `arlen=0` and `arlen=15` respectively; data matches the beats for every word.
